// File: rtl/definitions_pkg.sv
// -----------------------------------------------------------------------------
// definitions_pkg
// Shared constants for the load path and the state type of the control-read
// buffer writer.
//   MAX_LOAD_WIDTH      features moved per FIFO word
//   FEATURE_BIT_SIZE    bits per feature
//   MAX_INPUT_BUF_SIZE  entries in the input feature buffer (deliberately not a
//                       power of two, so the address wrap is a real compare)
//   ctrlread_wr_state_t IDLE / RUN / DRAIN / FINISH
// -----------------------------------------------------------------------------
package definitions_pkg;

    localparam int MAX_LOAD_WIDTH     = 4;
    localparam int FEATURE_BIT_SIZE   = 8;
    localparam int MAX_INPUT_BUF_SIZE = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } ctrlread_wr_state_t;

endpackage

// File: rtl/ctrlread_buf_writer.sv
// -----------------------------------------------------------------------------
// ctrlread_buf_writer
// Pops num_words words from the control-read data FIFO and writes them into
// the input feature buffer starting at base_addr, wrapping at BUF_DEPTH.
// Ends with a one-cycle done pulse, or an aborted pulse after a clean abort.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               launch a transfer (sampled in IDLE only)
//   base_addr           first buffer address (< BUF_DEPTH)
//   num_words           words to move, 0..BUF_DEPTH
//   abort               cancel the transfer in progress
//   busy                transfer in progress
//   done / aborted      one-cycle completion pulses (mutually exclusive)
//   fifo_dout           FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty          FIFO empty flag
//   fifo_rd_en          FIFO pop (combinational)
//   buf_wr_en           buffer write strobe (registered)
//   buf_addr            buffer write address (registered)
//   buf_wdata           buffer write data (pass-through of fifo_dout)
// -----------------------------------------------------------------------------
module ctrlread_buf_writer
    import definitions_pkg::*;
#(
    parameter int WIDTH      = MAX_LOAD_WIDTH * FEATURE_BIT_SIZE,
    parameter int BUF_DEPTH  = MAX_INPUT_BUF_SIZE,
    parameter int ADDR_WIDTH = $clog2(BUF_DEPTH),
    parameter int LEN_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_words,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    input  logic [WIDTH-1:0]      fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  buf_wr_en,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [WIDTH-1:0]      buf_wdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUF_DEPTH - 1);

    ctrlread_wr_state_t    state_q, state_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  num_q, num_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  abort_flag_q, abort_flag_d;
    logic                  rd_en_q, rd_en_d;

    // -------------------------------------------------------------------------
    // Next-state and pop decision
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        issued_d     = issued_q;
        num_d        = num_q;
        addr_d       = addr_q;
        abort_flag_d = abort_flag_q;
        rd_en_d      = 1'b0;

        // The write address advances after every write landing this cycle.
        if (rd_en_q) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_d        = num_words;
                    issued_d     = '0;
                    addr_d       = base_addr;
                    abort_flag_d = 1'b0;
                    state_d      = (num_words == '0) ? FINISH : RUN;
                end
            end

            RUN: begin
                rd_en_d = !fifo_empty && !abort && (issued_q < num_q);
                if (abort) begin
                    abort_flag_d = 1'b1;
                    state_d      = DRAIN;
                end else if (rd_en_d) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_d == num_q) begin
                        state_d = DRAIN;
                    end
                end
            end

            // Nothing is popped in DRAIN, so the only pop still in flight is
            // the one being written this cycle; once it lands we can finish.
            DRAIN:   state_d = FINISH;

            FINISH:  state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= IDLE;
            issued_q     <= '0;
            num_q        <= '0;
            addr_q       <= '0;
            abort_flag_q <= 1'b0;
            rd_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            num_q        <= num_d;
            addr_q       <= addr_d;
            abort_flag_q <= abort_flag_d;
            rd_en_q      <= rd_en_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH) && !abort_flag_q;
    assign aborted    = (state_q == FINISH) &&  abort_flag_q;
    assign fifo_rd_en = rd_en_d;
    assign buf_wr_en  = rd_en_q;
    assign buf_addr   = addr_q;
    assign buf_wdata  = fifo_dout;

endmodule

// File: tb/tb_ctrlread_buf_writer.sv
// -----------------------------------------------------------------------------
// tb_ctrlread_buf_writer
// Bench for ctrlread_buf_writer: a queue-based FIFO feeds the DUT, and a
// timeline model (pop cycles, write one cycle after each pop, completion two
// cycles after the last pop or the abort) is compared against the outputs on
// every falling edge. Directed cases pin the model with literal expectations;
// random transactions follow.
// -----------------------------------------------------------------------------
module tb_ctrlread_buf_writer;
    import definitions_pkg::*;

    localparam int W     = MAX_LOAD_WIDTH * FEATURE_BIT_SIZE;
    localparam int DEPTH = MAX_INPUT_BUF_SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] num_words;
    logic          abort;
    logic          busy, done, aborted;
    logic [W-1:0]  fifo_dout = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          buf_wr_en;
    logic [AW-1:0] buf_addr;
    logic [W-1:0]  buf_wdata;

    always #5 clk = ~clk;

    ctrlread_buf_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .buf_wr_en  (buf_wr_en),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------------------
    // FIFO: contents in fifo_q, the same words in mdl_q for the model
    // -------------------------------------------------------------------------
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] mdl_q[$];
    int           n_pops = 0;

    always @(posedge clk) begin
        if (!rst && fifo_rd_en) begin
            n_pops++;
            check("pop_while_fifo_nonempty", 64'(fifo_q.size() == 0), 64'd0);
            if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        end
    end

    int   empty_mode = 0;   // 0 never, 1 every other cycle, 2 random
    logic toggle_ph  = 1'b0;

    task automatic update_empty();
        toggle_ph  = ~toggle_ph;
        fifo_empty = (fifo_q.size() == 0) ||
                     (empty_mode == 1 && toggle_ph) ||
                     (empty_mode == 2 && $urandom_range(0, 2) == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update_empty();
    endtask

    // -------------------------------------------------------------------------
    // Timeline model and per-cycle compare
    // -------------------------------------------------------------------------
    logic         m_active = 1'b0;
    logic         m_ab     = 1'b0;
    int           m_start  = 0;
    int           m_end    = -1;
    int           m_n      = 0;
    int           m_pops   = 0;
    int           m_base   = 0;
    logic         m_wr_pend = 1'b0;
    logic [W-1:0] m_wr_data = '0;
    int           m_wr_addr = 0;

    int n_writes = 0, n_done = 0, n_aborted = 0, done_cyc = -1, first_wr_cyc = -1;
    int wr_addrs[$];

    logic issuing, exp_rd;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_busy",       64'(busy),       64'd0);
            check("rst_done",       64'(done),       64'd0);
            check("rst_aborted",    64'(aborted),    64'd0);
            check("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
            check("rst_buf_wr_en",  64'(buf_wr_en),  64'd0);
            check("rst_buf_addr",   64'(buf_addr),   64'd0);
            m_active  = 1'b0;
            m_wr_pend = 1'b0;
        end else begin
            issuing = m_active && (cyc > m_start) && (m_end < 0);
            exp_rd  = issuing && (m_pops < m_n) && !fifo_empty && !abort;

            check("busy",       64'(busy),       64'(m_active && cyc > m_start));
            check("done",       64'(done),       64'(m_active && cyc == m_end && !m_ab));
            check("aborted",    64'(aborted),    64'(m_active && cyc == m_end && m_ab));
            check("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
            check("buf_wr_en",  64'(buf_wr_en),  64'(m_wr_pend));
            if (m_wr_pend) begin
                check("buf_addr",  64'(buf_addr),  64'(m_wr_addr));
                check("buf_wdata", 64'(buf_wdata), 64'(m_wr_data));
            end

            if (buf_wr_en) begin
                if (n_writes == 0) first_wr_cyc = cyc;
                n_writes++;
                wr_addrs.push_back(int'(buf_addr));
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (aborted) n_aborted++;

            // Each pop is written one cycle later at base + pop index.
            m_wr_pend = exp_rd;
            if (exp_rd) begin
                m_wr_data = (mdl_q.size() > 0) ? mdl_q.pop_front() : '0;
                m_wr_addr = (m_base + m_pops) % DEPTH;
                m_pops++;
                if (m_pops == m_n) m_end = cyc + 2;
            end else if (issuing && abort) begin
                m_ab  = 1'b1;
                m_end = cyc + 2;
            end

            if (m_active && cyc == m_end) begin
                m_active = 1'b0;
            end else if (!m_active && start) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_n      = int'(num_words);
                m_base   = int'(base_addr);
                m_pops   = 0;
                m_ab     = 1'b0;
                m_end    = (num_words == '0) ? cyc + 1 : -1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Transaction driver
    // -------------------------------------------------------------------------
    int txn_start = 0;

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        mdl_q.push_back(w);
    endtask

    task automatic run_txn(input int base, input int n, input int extra, input bit seq,
                           input int mode, input int abort_after, input int rst_after,
                           input bit noise);
        bit finished;
        bit abort_sent;
        fifo_q.delete();
        mdl_q.delete();
        for (int i = 0; i < n + extra; i++) push_word(seq ? W'(i + 1) : W'($urandom));
        n_writes = 0; n_done = 0; n_aborted = 0; n_pops = 0;
        done_cyc = -1; first_wr_cyc = -1;
        wr_addrs.delete();
        empty_mode = mode;
        update_empty();

        base_addr = AW'(base);
        num_words = LW'(n);
        start     = 1'b1;
        txn_start = cyc;
        tick();
        start      = 1'b0;
        finished   = 1'b0;
        abort_sent = 1'b0;

        for (int i = 0; i < 400 && !finished; i++) begin
            abort = 1'b0;
            if (n_done + n_aborted > 0) begin
                finished = 1'b1;
            end else if (rst_after >= 0 && n_writes == rst_after) begin
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
                fifo_q.delete();
                mdl_q.delete();
                update_empty();
                return;
            end else begin
                if (abort_after >= 0 && !abort_sent && n_pops == abort_after) begin
                    abort      = 1'b1;
                    abort_sent = 1'b1;
                end
                if (noise) begin
                    start     = ($urandom_range(0, 5) == 0);
                    base_addr = AW'($urandom_range(0, DEPTH - 1));
                    num_words = LW'($urandom_range(0, DEPTH));
                end
                tick();
                start = 1'b0;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        check("txn_completes", 64'(finished), 64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        num_words  = '0;
        fifo_empty = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic run: 0x1..0x8 to addresses 0..7
        run_txn(0, 8, 0, 1'b1, 0, -1, -1, 1'b0);
        check("basic_writes",     64'(n_writes),                64'd8);
        check("basic_pops",       64'(n_pops),                  64'd8);
        check("basic_first_wr",   64'(first_wr_cyc - txn_start), 64'd2);
        check("basic_done_cycle", 64'(done_cyc - txn_start),     64'd10);
        check("basic_last_addr",  64'(wr_addrs[7]),              64'd7);
        tick();

        // Wrap at a non-power-of-two depth
        run_txn(DEPTH - 2, 4, 0, 1'b1, 0, -1, -1, 1'b0);
        check("wrap_addr0", 64'(wr_addrs[0]), 64'(DEPTH - 2));
        check("wrap_addr1", 64'(wr_addrs[1]), 64'(DEPTH - 1));
        check("wrap_addr2", 64'(wr_addrs[2]), 64'd0);
        check("wrap_addr3", 64'(wr_addrs[3]), 64'd1);

        // Bubbles every other cycle
        run_txn(3, 5, 0, 1'b1, 1, -1, -1, 1'b0);
        check("bubble_writes", 64'(n_writes), 64'd5);
        check("bubble_done",   64'(n_done),   64'd1);

        // Zero length
        run_txn(5, 0, 2, 1'b1, 0, -1, -1, 1'b0);
        check("zero_done_cycle", 64'(done_cyc - txn_start), 64'd1);
        check("zero_pops",       64'(n_pops),               64'd0);
        check("zero_writes",     64'(n_writes),             64'd0);

        // Abort after the 3rd pop
        run_txn(0, 10, 0, 1'b1, 0, 3, -1, 1'b0);
        check("abort_writes",  64'(n_writes),      64'd3);
        check("abort_pulse",   64'(n_aborted),     64'd1);
        check("abort_no_done", 64'(n_done),        64'd0);
        check("abort_left",    64'(fifo_q.size()), 64'd7);

        // Reset after 4 writes, then a normal short run
        run_txn(0, 8, 0, 1'b1, 0, -1, 4, 1'b0);
        check("rst_no_done", 64'(n_done + n_aborted), 64'd0);
        tick();
        run_txn(6, 2, 0, 1'b1, 0, -1, -1, 1'b0);
        check("post_rst_writes", 64'(n_writes), 64'd2);
        check("post_rst_done",   64'(n_done),   64'd1);

        // Random transactions
        for (int t = 0; t < 60; t++) begin
            int n;
            n = $urandom_range(0, DEPTH);
            run_txn($urandom_range(0, DEPTH - 1), n, $urandom_range(0, 2), 1'b0,
                    $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1,
                    -1, 1'b1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
